// File: rtl/mem_stage_if.sv
// Signal bundle between the EX stage, the memory stage, the data memory and writeback.
// The slave modport is the memory stage's view; master is the view of its environment.
interface mem_stage_if;
    // EX-stage result
    logic        i_valid;
    logic [31:0] i_alu_out;
    logic [31:0] i_store_data;
    logic [2:0]  i_func3;
    logic [4:0]  i_rd;
    logic        i_mem_read;
    logic        i_mem_write;
    logic        i_mem_to_reg;
    logic        i_reg_write;
    logic        o_stall;

    // Data-memory port
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [31:0] o_dmem_wdata;
    logic [3:0]  o_dmem_be;
    logic        i_dmem_ack;
    logic [31:0] i_dmem_rdata;

    // Writeback
    logic        o_wb_valid;
    logic [4:0]  o_wb_rd;
    logic [31:0] o_wb_data;
    logic        o_wb_reg_write;
    logic        o_misaligned;

    modport slave (
        input  i_valid, i_alu_out, i_store_data, i_func3, i_rd,
        input  i_mem_read, i_mem_write, i_mem_to_reg, i_reg_write,
        output o_stall,
        output o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata, o_dmem_be,
        input  i_dmem_ack, i_dmem_rdata,
        output o_wb_valid, o_wb_rd, o_wb_data, o_wb_reg_write, o_misaligned
    );

    modport master (
        output i_valid, i_alu_out, i_store_data, i_func3, i_rd,
        output i_mem_read, i_mem_write, i_mem_to_reg, i_reg_write,
        input  o_stall,
        input  o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata, o_dmem_be,
        output i_dmem_ack, i_dmem_rdata,
        input  o_wb_valid, o_wb_rd, o_wb_data, o_wb_reg_write, o_misaligned
    );
endinterface

// File: rtl/mem_stage.sv
// Pipeline memory stage. Non-memory results pass straight to writeback one cycle later;
// aligned loads/stores issue a single data-memory request and hold the pipeline (o_stall)
// until the memory acknowledges. Misaligned or contradictory accesses never reach memory and
// are reported through o_misaligned instead.
module mem_stage (
    input  logic       i_clk,
    input  logic       i_reset,
    mem_stage_if.slave bus
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    state_e      state_q, state_d;

    // Outstanding request (held constant for the whole WAIT state)
    logic        dmem_req_q;
    logic        dmem_we_q;
    logic [31:0] alu_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [2:0]  func3_q;
    logic [4:0]  rd_q;
    logic        mem_to_reg_q;
    logic        ld_reg_write_q;

    // Writeback register
    logic        wb_valid_q;
    logic [4:0]  wb_rd_q;
    logic [31:0] wb_data_q;
    logic        wb_reg_write_q;
    logic        misaligned_q;

    logic [1:0]  size;
    logic        is_mem;
    logic        bad_access;
    logic        accept;
    logic        start_alu;
    logic        start_err;
    logic        start_mem;
    logic        ack_done;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] ld_lane;
    logic [31:0] ld_data;

    // Classify the op offered by EX; only IDLE accepts anything, WAIT ignores i_valid.
    assign size       = bus.i_func3[1:0];
    assign is_mem     = bus.i_mem_read | bus.i_mem_write;
    assign bad_access = (bus.i_mem_read & bus.i_mem_write)
                      | ((size == SZ_H) & bus.i_alu_out[0])
                      | ((size == SZ_W) & (bus.i_alu_out[1:0] != 2'b00))
                      | (size == 2'd3);
    assign accept     = (state_q == ST_IDLE) & bus.i_valid;
    assign start_alu  = accept & ~is_mem;
    assign start_err  = accept & is_mem & bad_access;
    assign start_mem  = accept & is_mem & ~bad_access;
    // An ack outside WAIT belongs to no request of ours and is dropped.
    assign ack_done   = (state_q == ST_WAIT) & bus.i_dmem_ack;

    // Byte-lane enables and lane-replicated write data for the access being captured
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves it unassigned (no latch).
        st_be    = 4'b1111;
        st_wdata = bus.i_store_data;
        case (size)
            SZ_B: begin
                st_be    = 4'b0001 << bus.i_alu_out[1:0];
                st_wdata = {4{bus.i_store_data[7:0]}};
            end
            SZ_H: begin
                st_be    = 4'b0011 << bus.i_alu_out[1:0];
                st_wdata = {2{bus.i_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Pick the addressed lane out of the returned word and extend it to 32 bits
    always_comb begin
        ld_lane = bus.i_dmem_rdata >> {alu_q[1:0], 3'b000};
        ld_data = ld_lane;
        case (func3_q)
            3'd0:    ld_data = {{24{ld_lane[7]}}, ld_lane[7:0]};
            3'd1:    ld_data = {{16{ld_lane[15]}}, ld_lane[15:0]};
            3'd4:    ld_data = {24'd0, ld_lane[7:0]};
            3'd5:    ld_data = {16'd0, ld_lane[15:0]};
            default: ;
        endcase
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!i_reset) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // FSM next state: IDLE -> WAIT on an issued access, WAIT -> IDLE on ack
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_mem) state_d = ST_WAIT;
            ST_WAIT: if (ack_done)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM output: hold EX while an access is being captured or is outstanding
    always_comb begin
        bus.o_stall = 1'b0;
        case (state_q)
            ST_IDLE: bus.o_stall = start_mem;
            ST_WAIT: bus.o_stall = 1'b1;
            default: bus.o_stall = 1'b0;
        endcase
    end

    // Request and writeback registers; writeback pulses last exactly one cycle
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            dmem_req_q     <= 1'b0;
            dmem_we_q      <= 1'b0;
            alu_q          <= '0;
            wdata_q        <= '0;
            be_q           <= '0;
            func3_q        <= '0;
            rd_q           <= '0;
            mem_to_reg_q   <= 1'b0;
            ld_reg_write_q <= 1'b0;
            wb_valid_q     <= 1'b0;
            wb_rd_q        <= '0;
            wb_data_q      <= '0;
            wb_reg_write_q <= 1'b0;
            misaligned_q   <= 1'b0;
        end else begin
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            misaligned_q   <= 1'b0;

            if (start_alu) begin
                wb_valid_q     <= 1'b1;
                wb_rd_q        <= bus.i_rd;
                wb_data_q      <= bus.i_alu_out;
                wb_reg_write_q <= bus.i_reg_write & (bus.i_rd != 5'd0);
            end

            if (start_err) begin
                wb_valid_q   <= 1'b1;
                wb_rd_q      <= bus.i_rd;
                wb_data_q    <= bus.i_alu_out;
                misaligned_q <= 1'b1;
            end

            if (start_mem) begin
                dmem_req_q     <= 1'b1;
                dmem_we_q      <= bus.i_mem_write;
                alu_q          <= bus.i_alu_out;
                wdata_q        <= st_wdata;
                be_q           <= st_be;
                func3_q        <= bus.i_func3;
                rd_q           <= bus.i_rd;
                mem_to_reg_q   <= bus.i_mem_to_reg;
                ld_reg_write_q <= bus.i_mem_read & bus.i_reg_write & (bus.i_rd != 5'd0);
            end

            if (ack_done) begin
                dmem_req_q     <= 1'b0;
                dmem_we_q      <= 1'b0;
                be_q           <= 4'b0000;
                wb_valid_q     <= 1'b1;
                wb_rd_q        <= rd_q;
                wb_data_q      <= mem_to_reg_q ? ld_data : alu_q;
                wb_reg_write_q <= ld_reg_write_q;
            end
        end
    end

    assign bus.o_dmem_req     = dmem_req_q;
    assign bus.o_dmem_we      = dmem_we_q;
    assign bus.o_dmem_addr    = {alu_q[31:2], 2'b00};
    assign bus.o_dmem_wdata   = wdata_q;
    assign bus.o_dmem_be      = be_q;
    assign bus.o_wb_valid     = wb_valid_q;
    assign bus.o_wb_rd        = wb_rd_q;
    assign bus.o_wb_data      = wb_data_q;
    assign bus.o_wb_reg_write = wb_reg_write_q;
    assign bus.o_misaligned   = misaligned_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios with literal expectations, then randomized traffic
// against a transaction-level model of the stage checked on every falling clock edge.
module tb_mem_stage;

    logic i_clk = 1'b0;
    logic i_reset;

    mem_stage_if bus ();

    mem_stage dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference rules ----------------
    function automatic int unsigned access_bytes(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic bit access_ok(input logic mr, input logic mw, input logic [2:0] f3,
                                     input logic [31:0] addr);
        if (mr && mw) return 1'b0;
        return (addr % access_bytes(f3)) == 0;
    endfunction

    function automatic logic [31:0] load_value(input logic [31:0] word, input logic [31:0] addr,
                                               input logic [2:0] f3);
        int unsigned off;
        logic [31:0] b;
        logic [31:0] h;
        off = addr % 4;
        b = (word >> (8 * off)) & 32'hFF;
        h = (word >> (8 * off)) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128)   ? b + 32'hFFFF_FF00 : b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return word;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [31:0] addr);
        int unsigned n;
        n = access_bytes(f3);
        if (n == 4) return 4'b1111;
        return 4'(((1 << n) - 1) << (addr % 4));
    endfunction

    function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] sd);
        case (access_bytes(f3))
            1:       return (sd & 32'hFF) * 32'h0101_0101;
            2:       return (sd & 32'hFFFF) * 32'h0001_0001;
            default: return sd;
        endcase
    endfunction

    // ---------------- model state ----------------
    bit          m_busy;
    bit          exp_stall;
    logic        e_req, e_we, e_wb_valid, e_mis, e_rw;
    bit          e_chk_data;
    logic [31:0] e_addr, e_wdata, e_data;
    logic [3:0]  e_be;
    logic [4:0]  e_rd;
    logic        p_load, p_m2r, p_rw;
    logic [4:0]  p_rd;
    logic [31:0] p_alu;
    logic [2:0]  p_f3;

    initial begin
        m_busy = 0; e_req = 0; e_we = 0; e_wb_valid = 0; e_mis = 0; e_rw = 0; e_chk_data = 0;
        e_addr = 0; e_wdata = 0; e_data = 0; e_be = 0; e_rd = 0;
        p_load = 0; p_m2r = 0; p_rw = 0; p_rd = 0; p_alu = 0; p_f3 = 0;
    end

    // Compare on the falling edge, then advance the model with the inputs the DUT sees next edge
    always @(negedge i_clk) begin
        if (!i_reset) begin
            check("rst_stall",        32'(bus.o_stall),        32'd0);
            check("rst_dmem_req",     32'(bus.o_dmem_req),     32'd0);
            check("rst_dmem_we",      32'(bus.o_dmem_we),      32'd0);
            check("rst_dmem_be",      32'(bus.o_dmem_be),      32'd0);
            check("rst_dmem_addr",    bus.o_dmem_addr,         32'd0);
            check("rst_dmem_wdata",   bus.o_dmem_wdata,        32'd0);
            check("rst_wb_valid",     32'(bus.o_wb_valid),     32'd0);
            check("rst_wb_rd",        32'(bus.o_wb_rd),        32'd0);
            check("rst_wb_data",      bus.o_wb_data,           32'd0);
            check("rst_wb_reg_write", 32'(bus.o_wb_reg_write), 32'd0);
            check("rst_misaligned",   32'(bus.o_misaligned),   32'd0);
            m_busy = 0; e_req = 0; e_we = 0; e_wb_valid = 0; e_mis = 0;
        end else begin
            exp_stall = m_busy || (bus.i_valid && (bus.i_mem_read || bus.i_mem_write) &&
                        access_ok(bus.i_mem_read, bus.i_mem_write, bus.i_func3, bus.i_alu_out));
            check("stall",      32'(bus.o_stall),      32'(exp_stall));
            check("wb_valid",   32'(bus.o_wb_valid),   32'(e_wb_valid));
            check("misaligned", 32'(bus.o_misaligned), 32'(e_mis));
            check("dmem_req",   32'(bus.o_dmem_req),   32'(e_req));
            if (e_wb_valid) begin
                check("wb_rd",        32'(bus.o_wb_rd),        32'(e_rd));
                check("wb_reg_write", 32'(bus.o_wb_reg_write), 32'(e_rw));
                if (e_chk_data) check("wb_data", bus.o_wb_data, e_data);
            end
            if (e_req) begin
                check("dmem_we",   32'(bus.o_dmem_we), 32'(e_we));
                check("dmem_addr", bus.o_dmem_addr,    e_addr);
                if (e_we) begin
                    check("dmem_be",    32'(bus.o_dmem_be), 32'(e_be));
                    check("dmem_wdata", bus.o_dmem_wdata,   e_wdata);
                end
            end

            e_wb_valid = 0;
            e_mis      = 0;
            if (m_busy) begin
                if (bus.i_dmem_ack) begin
                    m_busy     = 0;
                    e_req      = 0;
                    e_we       = 0;
                    e_wb_valid = 1;
                    e_rd       = p_rd;
                    e_chk_data = 1;
                    e_data     = p_m2r ? load_value(bus.i_dmem_rdata, p_alu, p_f3) : p_alu;
                    e_rw       = p_load && p_rw && (p_rd != 0);
                end
            end else if (bus.i_valid) begin
                if (!bus.i_mem_read && !bus.i_mem_write) begin
                    e_wb_valid = 1;
                    e_rd       = bus.i_rd;
                    e_chk_data = 1;
                    e_data     = bus.i_alu_out;
                    e_rw       = bus.i_reg_write && (bus.i_rd != 0);
                end else if (!access_ok(bus.i_mem_read, bus.i_mem_write, bus.i_func3,
                                        bus.i_alu_out)) begin
                    e_wb_valid = 1;
                    e_mis      = 1;
                    e_rd       = bus.i_rd;
                    e_chk_data = 0;
                    e_rw       = 0;
                end else begin
                    m_busy  = 1;
                    e_req   = 1;
                    e_we    = bus.i_mem_write;
                    e_addr  = bus.i_alu_out - (bus.i_alu_out % 4);
                    e_be    = lane_mask(bus.i_func3, bus.i_alu_out);
                    e_wdata = lane_data(bus.i_func3, bus.i_store_data);
                    p_load  = bus.i_mem_read;
                    p_m2r   = bus.i_mem_to_reg;
                    p_rw    = bus.i_reg_write;
                    p_rd    = bus.i_rd;
                    p_alu   = bus.i_alu_out;
                    p_f3    = bus.i_func3;
                end
            end
        end
    end

    // ---------------- data-memory responder ----------------
    int          resp_delay = 0;      // cycles of req before ack; negative = random 0..3
    logic [31:0] resp_rdata = '0;
    bit          resp_rand  = 0;
    bit          stray_rand = 0;
    bit          stray_ack  = 0;
    bit          r_active   = 0;
    int          r_cnt      = 0;
    int          r_delay    = 0;

    initial begin
        bus.i_dmem_ack   = 1'b0;
        bus.i_dmem_rdata = '0;
        forever begin
            @(posedge i_clk);
            #2;
            bus.i_dmem_ack = 1'b0;
            if (stray_ack) begin
                bus.i_dmem_ack = 1'b1;
                bus.i_dmem_rdata = 32'hDEAD_BEEF;
            end else if (!i_reset || !bus.o_dmem_req) begin
                r_active = 0;
                if (stray_rand && $urandom_range(0, 9) == 0) begin
                    bus.i_dmem_ack   = 1'b1;
                    bus.i_dmem_rdata = $urandom;
                end
            end else begin
                if (!r_active) begin
                    r_active = 1;
                    r_cnt    = 0;
                    r_delay  = (resp_delay < 0) ? int'($urandom_range(0, 3)) : resp_delay;
                end
                if (r_cnt == r_delay) begin
                    bus.i_dmem_ack   = 1'b1;
                    bus.i_dmem_rdata = resp_rand ? $urandom : resp_rdata;
                end
                r_cnt++;
            end
        end
    end

    // ---------------- stimulus ----------------
    logic        acc_wb_valid;
    logic [31:0] acc_wb_data;

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    // Present an op and hold it until the stage is free to take it; returns 1 unit after the
    // edge that captured it.
    task automatic issue(input logic mr, input logic mw, input logic m2r, input logic rw,
                         input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] sd);
        bus.i_valid      = 1'b1;
        bus.i_mem_read   = mr;
        bus.i_mem_write  = mw;
        bus.i_mem_to_reg = m2r;
        bus.i_reg_write  = rw;
        bus.i_func3      = f3;
        bus.i_rd         = rd;
        bus.i_alu_out    = alu;
        bus.i_store_data = sd;
        for (int n = 0; n < 100; n++) begin
            @(negedge i_clk);
            if (!bus.o_dmem_req) break;
            @(posedge i_clk);
            #1;
        end
        check("accept_in_time", 32'(bus.o_dmem_req), 32'd0);
        acc_wb_valid = bus.o_wb_valid;
        acc_wb_data  = bus.o_wb_data;
        @(posedge i_clk);
        #1;
        bus.i_valid = 1'b0;
    endtask

    task automatic wait_wb(output int n);
        n = 0;
        do begin
            @(posedge i_clk);
            #1;
            n++;
        end while (!bus.o_wb_valid && n < 50);
        check("wb_in_time", 32'(bus.o_wb_valid), 32'd1);
    endtask

    logic [2:0] ld_f3 [5];
    int         lat;
    int         kind;
    logic [31:0] r_alu;
    logic [4:0]  r_rd;

    initial begin
        ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        bus.i_valid = 0; bus.i_mem_read = 0; bus.i_mem_write = 0; bus.i_mem_to_reg = 0;
        bus.i_reg_write = 0; bus.i_func3 = 0; bus.i_rd = 0; bus.i_alu_out = 0; bus.i_store_data = 0;
        i_reset = 1'b1;
        #1 i_reset = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check("reset_wb_valid", 32'(bus.o_wb_valid), 32'd0);
        check("reset_dmem_be",  32'(bus.o_dmem_be),  32'd0);

        // ADD right after reset release: accepted on the first edge
        i_reset = 1'b1;
        issue(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 5'd5, 32'h0000_1234, 32'd0);
        check("add_wb_valid", 32'(bus.o_wb_valid),     32'd1);
        check("add_wb_data",  bus.o_wb_data,           32'h0000_1234);
        check("add_wb_rd",    32'(bus.o_wb_rd),        32'd5);
        check("add_wb_rw",    32'(bus.o_wb_reg_write), 32'd1);
        check("add_no_req",   32'(bus.o_dmem_req),     32'd0);
        idle(1);

        // LB 0x103, ack on the 4th request cycle
        resp_delay = 3;
        resp_rdata = 32'h80FF_0000;
        issue(1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 5'd6, 32'h0000_0103, 32'd0);
        check("lb_addr",  bus.o_dmem_addr,    32'h0000_0100);
        check("lb_stall", 32'(bus.o_stall),   32'd1);
        check("lb_we",    32'(bus.o_dmem_we), 32'd0);
        wait_wb(lat);
        check("lb_latency", 32'(lat),     32'd4);
        check("lb_wb_data", bus.o_wb_data, 32'hFFFF_FF80);

        // SH 0x202
        resp_delay = 1;
        issue(1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 5'd8, 32'h0000_0202, 32'h0000_BEEF);
        check("sh_be",    32'(bus.o_dmem_be), 32'h0000_000C);
        check("sh_wdata", bus.o_dmem_wdata,   32'hBEEF_BEEF);
        check("sh_we",    32'(bus.o_dmem_we), 32'd1);
        wait_wb(lat);
        check("sh_wb_rw", 32'(bus.o_wb_reg_write), 32'd0);

        // LW 0x101 misaligned
        issue(1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 5'd9, 32'h0000_0101, 32'd0);
        check("lw_mis_req",   32'(bus.o_dmem_req),     32'd0);
        check("lw_mis_flag",  32'(bus.o_misaligned),   32'd1);
        check("lw_mis_valid", 32'(bus.o_wb_valid),     32'd1);
        check("lw_mis_rw",    32'(bus.o_wb_reg_write), 32'd0);
        idle(1);
        check("lw_mis_one_cycle", 32'(bus.o_misaligned), 32'd0);

        // Read and write both set: error path
        issue(1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 5'd11, 32'h0000_0010, 32'd0);
        check("rw_both_req",  32'(bus.o_dmem_req),   32'd0);
        check("rw_both_flag", 32'(bus.o_misaligned), 32'd1);

        // rd = 0 never writes the register file
        issue(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 5'd0, 32'h0000_0077, 32'd0);
        check("rd0_rw", 32'(bus.o_wb_reg_write), 32'd0);

        // Ack in the first request cycle: two-cycle latency
        resp_delay = 0;
        resp_rdata = 32'h1234_5678;
        issue(1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 5'd10, 32'h0000_0008, 32'd0);
        wait_wb(lat);
        check("fast_latency", 32'(lat),     32'd1);
        check("fast_wb_data", bus.o_wb_data, 32'h1234_5678);

        // LHU 0x2 abandoned by reset in WAIT, late ack ignored, then LW 0x0 works
        resp_delay = 1000;
        issue(1'b1, 1'b0, 1'b1, 1'b1, 3'd5, 5'd7, 32'h0000_0002, 32'd0);
        i_reset   = 1'b0;
        stray_ack = 1'b1;
        #1;
        check("abort_req",      32'(bus.o_dmem_req), 32'd0);
        check("abort_stall",    32'(bus.o_stall),    32'd0);
        check("abort_wb_valid", 32'(bus.o_wb_valid), 32'd0);
        check("abort_addr",     bus.o_dmem_addr,     32'd0);
        idle(2);
        i_reset = 1'b1;
        idle(1);
        check("late_ack_wb_valid", 32'(bus.o_wb_valid), 32'd0);
        check("late_ack_req",      32'(bus.o_dmem_req), 32'd0);
        stray_ack  = 1'b0;
        resp_delay = 0;
        resp_rdata = 32'h1122_3344;
        issue(1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 5'd12, 32'h0000_0000, 32'd0);
        wait_wb(lat);
        check("post_rst_lw_data", bus.o_wb_data, 32'h1122_3344);

        // LW followed by an ADD held behind it
        resp_delay = 2;
        resp_rdata = 32'hCAFE_F00D;
        issue(1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 5'd3, 32'h0000_0040, 32'd0);
        issue(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 5'd4, 32'h0000_0055, 32'd0);
        check("b2b_lw_wb_valid", 32'(acc_wb_valid), 32'd1);
        check("b2b_lw_wb_data",  acc_wb_data,       32'hCAFE_F00D);
        check("b2b_add_valid",   32'(bus.o_wb_valid), 32'd1);
        check("b2b_add_data",    bus.o_wb_data,       32'h0000_0055);
        idle(1);
        check("b2b_no_dup", 32'(bus.o_wb_valid), 32'd0);

        // Randomized traffic, checked by the model every cycle
        resp_delay = -1;
        resp_rand  = 1;
        stray_rand = 1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            kind  = int'($urandom_range(0, 19));
            r_alu = $urandom;
            case ($urandom_range(0, 2))
                0:       ;
                1:       r_alu[0] = 1'b0;
                default: r_alu[1:0] = 2'b00;
            endcase
            r_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            if (kind < 5)
                issue(1'b0, 1'b0, 1'b0, 1'($urandom), 3'd0, r_rd, r_alu, $urandom);
            else if (kind < 12)
                issue(1'b1, 1'b0, 1'($urandom_range(0, 7) != 0), 1'($urandom),
                      ld_f3[$urandom_range(0, 4)], r_rd, r_alu, $urandom);
            else if (kind < 18)
                issue(1'b0, 1'b1, 1'b0, 1'($urandom), 3'($urandom_range(0, 2)), r_rd, r_alu,
                      $urandom);
            else
                issue(1'b1, 1'b1, 1'b0, 1'b1, 3'($urandom_range(0, 2)), r_rd, r_alu, $urandom);
        end
        stray_rand = 0;
        idle(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got t=%0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: i_clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have i_reset  in  1  asynchronous, active-low reset (0 = reset).
REQ-003 SHALL have i_valid  in  1  EX-stage result valid this cycle.
REQ-004 SHALL have i_alu_out  in  32  ALU result (effective address for loads/stores).
REQ-005 SHALL have i_store_data  in  32  store operand (rs2 value).
REQ-006 SHALL have i_func3  in  3  width code: 0 B, 1 H, 2 W, 4 BU, 5 HU.
REQ-007 SHALL have i_rd  in  5, i_mem_read  in  1, i_mem_write  in  1, i_mem_to_reg  in  1, i_reg_write  in  1.
REQ-008 SHALL have o_stall  out  1  upstream hold; EX keeps all inputs stable while high.
REQ-009 SHALL have o_dmem_req  out  1, o_dmem_we  out  1, o_dmem_addr  out  32 (bits [1:0] = 0), o_dmem_wdata  out  32, o_dmem_be  out  4.
REQ-010 SHALL have i_dmem_ack  in  1, i_dmem_rdata  in  32 (word, valid with ack).
REQ-011 SHALL have o_wb_valid  out  1, o_wb_rd  out  5, o_wb_data  out  32, o_wb_reg_write  out  1, o_misaligned  out  1.

Function
REQ-012 SHALL implement FSM states IDLE and WAIT; o_stall = (state == WAIT) OR (IDLE AND capturing a memory op).
REQ-013 Non-memory op (i_valid, !i_mem_read, !i_mem_write) in IDLE SHALL produce o_wb_valid=1 next cycle, o_wb_data=i_alu_out, o_wb_rd=i_rd, o_wb_reg_write=i_reg_write.
REQ-014 Aligned memory op in IDLE SHALL register request; next cycle state=WAIT, o_dmem_req=1, o_dmem_we=i_mem_write.
REQ-015 o_dmem_req and all o_dmem_* SHALL stay constant in WAIT until i_dmem_ack=1 is sampled.
REQ-016 On ack sampled in WAIT: next cycle state=IDLE, o_dmem_req=0, o_wb_valid=1 for one cycle, o_stall=0.
REQ-017 Store byte enables: B -> 4'b0001<<addr[1:0]; H -> 4'b0011<<addr[1:0]; W -> 4'b1111; wdata = byte/half replicated across lanes.
REQ-018 Load data: select lane by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W unchanged; o_wb_data = extended value when i_mem_to_reg=1.
REQ-019 Store completion SHALL give o_wb_valid=1, o_wb_reg_write=0.
REQ-020 Misaligned (H/HU addr[0]=1; W addr[1:0]!=0) SHALL issue no dmem request; next cycle o_misaligned=1 one cycle, o_wb_valid=1, o_wb_reg_write=0.
REQ-021 i_mem_read and i_mem_write both high SHALL be treated as misaligned (error path, no access).
REQ-022 i_dmem_ack in IDLE SHALL be ignored; i_valid while in WAIT SHALL be ignored (o_stall high).
REQ-023 rd=0 SHALL force o_wb_reg_write=0.
REQ-024 Ack arriving the same cycle request first asserts SHALL complete (minimum memory latency 2 cycles i_valid->o_wb_valid).

Reset
REQ-025 i_reset=0 SHALL asynchronously force state=IDLE, o_dmem_req=0, o_dmem_we=0, o_dmem_be=0, o_wb_valid=0, o_wb_reg_write=0, o_misaligned=0, o_stall=0; data outputs 0.
REQ-026 Reset during WAIT SHALL abandon the access; a subsequent late ack SHALL be ignored.
REQ-027 First transaction SHALL be accepted in the first cycle after i_reset rises.

Verification
REQ-028 ADD result 0x0000_1234, rd=5, reg_write=1 -> next cycle o_wb_valid=1, o_wb_data=0x1234, o_wb_rd=5, no dmem_req.
REQ-029 LB addr 0x103, rdata 0x80FF_0000, ack after 3 cycles -> dmem_addr 0x100, o_stall high throughout, o_wb_data 0xFFFF_FF80.
REQ-030 SH addr 0x202, data 0x0000_BEEF -> be=4'b1100, wdata=0xBEEF_BEEF, we=1, o_wb_reg_write=0.
REQ-031 LW addr 0x101 -> no dmem_req, o_misaligned=1 one cycle, o_wb_reg_write=0.
REQ-032 LHU addr 0x2, rdata 0x8001_0000, reset asserted in WAIT then ack -> all outputs 0, no o_wb_valid; next LW 0x0 completes normally.
REQ-033 Back-to-back: LW then ADD held by o_stall -> ADD writeback exactly one cycle after load writeback, no lost or duplicated o_wb_valid.
